imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_loader_byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Also holds the WordCount range check used when a load is requested.
package imem_pkg;

  localparam int          DEPTH_DEF     = 256;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0000;
  localparam int          ADDR_W        = 32;
  localparam int          COUNT_W       = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  // A load request is legal only for 1..depth words.
  function automatic logic count_ok(input logic [COUNT_W-1:0] n, input int depth);
    return (n != {COUNT_W{1'b0}}) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian 32-bit word from a byte stream.
// word_done flags the byte that completes the current word.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  cnt_r;
  logic [31:0] word_r;

  // Lane counter and word register; lane index wraps 3->0 after each word.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= 2'd0;
      word_r <= 32'd0;
    end else if (clear) begin
      cnt_r  <= 2'd0;
    end else if (byte_en) begin
      word_r[{cnt_r, 3'b000} +: 8] <= byte_in;
      cnt_r                        <= cnt_r + 2'd1;
    end
  end

  assign word      = word_r;
  assign word_done = byte_en && (cnt_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory and holds the CPU in reset
// until a complete program is resident.
module imem_loader
  import imem_pkg::*;
#(
  parameter int                DEPTH     = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [COUNT_W-1:0] WordCount,
  input  logic [7:0]         ByteData,
  input  logic               ByteValid,
  output logic               ByteReady,
  output logic               MemWe,
  output logic [ADDR_W-1:0]  MemAddr,
  output logic [31:0]        MemWData,
  output logic               CpuResetn,
  output logic               Busy,
  output logic               Done,
  output logic               Error
);

  localparam int IDX_W = $clog2(DEPTH) + 1;

  loader_state_t     state_r;
  loader_state_t     state_s;
  logic [COUNT_W-1:0] count_r;
  logic [IDX_W-1:0]   word_idx_r;
  logic               load_s;
  logic               reject_s;
  logic               byte_en_s;
  logic               word_done_s;
  logic               last_s;
  logic [31:0]        word_s;

  logic               byte_ready_r;
  logic               mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic               cpu_resetn_r;
  logic               busy_r;
  logic               done_r;
  logic               error_r;

  assign byte_en_s = ByteValid && (state_r == ST_RECV);
  assign last_s    = ((32'(word_idx_r) + 32'd1) == 32'(count_r));

  byte_packer u_packer (
    .clk       (Clk),
    .reset     (Reset),
    .clear     (load_s),
    .byte_in   (ByteData),
    .byte_en   (byte_en_s),
    .word      (word_s),
    .word_done (word_done_s)
  );

  // Next-state decode; Start is only honoured while idle or holding a program.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    reject_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          if (count_ok(WordCount, DEPTH)) begin
            state_s = ST_RECV;
            load_s  = 1'b1;
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_RECV: begin
        if (word_done_s) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_WRITE: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RECV;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      count_r      <= {COUNT_W{1'b0}};
      word_idx_r   <= {IDX_W{1'b0}};
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      cpu_resetn_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        count_r    <= WordCount;
        word_idx_r <= {IDX_W{1'b0}};
      end else if (state_r == ST_WRITE) begin
        word_idx_r <= word_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      // word_idx_r still points at the word being completed here.
      if (state_s == ST_WRITE) begin
        mem_addr_r <= BASE_ADDR + (32'(word_idx_r) << 2);
      end
      byte_ready_r <= (state_s == ST_RECV);
      mem_we_r     <= (state_s == ST_WRITE);
      busy_r       <= (state_s == ST_RECV) || (state_s == ST_WRITE);
      done_r       <= (state_s == ST_DONE);
      cpu_resetn_r <= (state_s == ST_DONE);
      error_r      <= reject_s;
    end
  end

  assign ByteReady = byte_ready_r;
  assign MemWe     = mem_we_r;
  assign MemAddr   = mem_addr_r;
  assign MemWData  = word_s;
  assign CpuResetn = cpu_resetn_r;
  assign Busy      = busy_r;
  assign Done      = done_r;
  assign Error     = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected memory writes are queued when the
// bytes are driven and compared as each MemWe appears.
module tb_imem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [8:0]  WordCount;
  logic [7:0]  ByteData;
  logic        ByteValid;
  logic        ByteReady;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        CpuResetn;
  logic        Busy;
  logic        Done;
  logic        Error;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  we_count = 0;

  imem_loader dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .WordCount (WordCount),
    .ByteData  (ByteData),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .CpuResetn (CpuResetn),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, and score any memory write.
  task automatic tick();
    wr_t e;
    @(posedge Clk);
    #1;
    if (MemWe === 1'b1) begin
      we_count++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr %h data %h expected no write",
               MemAddr, MemWData);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr", MemAddr, e.addr);
        chk("wr_data", MemWData, e.data);
      end
    end
  endtask

  task automatic start_load(input logic [8:0] n);
    WordCount = n;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
  endtask

  // Present a byte and hold it until the handshake completes (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic hs;
    hs        = 1'b0;
    ByteData  = b;
    ByteValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hs = ByteReady;
      tick();
      if (hs) break;
    end
    checks++;
    assert (hs) else begin
      errors++;
      $error("FAIL byte_timeout: observed no handshake expected handshake for %h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  bt;
    int          wc;
    Reset = 1'b1; Start = 1'b0; WordCount = 9'd0; ByteData = 8'd0; ByteValid = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("rst_ready",  {31'd0, ByteReady}, 32'd0);
    chk("rst_we",     {31'd0, MemWe},     32'd0);
    chk("rst_addr",   MemAddr,            32'd0);
    chk("rst_wdata",  MemWData,           32'd0);
    chk("rst_cpurn",  {31'd0, CpuResetn}, 32'd0);
    chk("rst_busy",   {31'd0, Busy},      32'd0);
    chk("rst_done",   {31'd0, Done},      32'd0);
    chk("rst_error",  {31'd0, Error},     32'd0);

    // Two-word load, bytes back-to-back.
    sb.push_back('{addr: 32'h0, data: 32'h0010_2083});
    sb.push_back('{addr: 32'h4, data: 32'h0020_2103});
    start_load(9'd2);
    chk("t1_busy",  {31'd0, Busy},      32'd1);
    chk("t1_ready", {31'd0, ByteReady}, 32'd1);
    chk("t1_cpurn_busy", {31'd0, CpuResetn}, 32'd0);
    send_byte(8'h83); send_byte(8'h20); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h21); send_byte(8'h20); send_byte(8'h00);
    ByteValid = 1'b0;
    tick();
    chk("t1_done",  {31'd0, Done},      32'd1);
    chk("t1_cpurn", {31'd0, CpuResetn}, 32'd1);
    chk("t1_busy0", {31'd0, Busy},      32'd0);
    chk("t1_nwrite", 32'(we_count),     32'd2);

    // Invalid Start in DONE: Error pulse, program stays resident.
    WordCount = 9'd0; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("done_err",   {31'd0, Error},     32'd1);
    chk("done_keep",  {31'd0, Done},      32'd1);
    chk("done_cpurn", {31'd0, CpuResetn}, 32'd1);
    tick();
    chk("done_err_pulse", {31'd0, Error}, 32'd0);

    // Reload from DONE, one word, ByteValid toggling every other cycle.
    start_load(9'd1);
    chk("t2_cpurn", {31'd0, CpuResetn}, 32'd0);
    chk("t2_done",  {31'd0, Done},      32'd0);
    chk("t2_busy",  {31'd0, Busy},      32'd1);
    sb.push_back('{addr: 32'h0, data: 32'hD4C3_B2A1});
    w = 32'hD4C3_B2A1;
    for (int i = 0; i < 4; i++) begin
      ByteData = w[8*i +: 8]; ByteValid = 1'b1;
      tick();
      ByteData = 8'hEE; ByteValid = 1'b0;
      tick();
    end
    chk("t2_nwrite", 32'(we_count), 32'd3);
    chk("t2_done1",  {31'd0, Done}, 32'd1);

    // Rejected counts in IDLE.
    Reset = 1'b1; tick(); Reset = 1'b0;
    WordCount = 9'd0; Start = 1'b1; tick(); Start = 1'b0;
    chk("idle_err0",  {31'd0, Error}, 32'd1);
    chk("idle_busy0", {31'd0, Busy},  32'd0);
    tick();
    chk("idle_err0_pulse", {31'd0, Error}, 32'd0);
    WordCount = 9'd257; Start = 1'b1; tick(); Start = 1'b0;
    chk("idle_err257",  {31'd0, Error},     32'd1);
    chk("idle_busy257", {31'd0, Busy},      32'd0);
    chk("idle_cpurn",   {31'd0, CpuResetn}, 32'd0);
    tick();
    chk("idle_err257_pulse", {31'd0, Error}, 32'd0);

    // Start while receiving is ignored; count is not re-sampled.
    sb.push_back('{addr: 32'h0, data: 32'h4433_2211});
    sb.push_back('{addr: 32'h4, data: 32'h8877_6655});
    start_load(9'd2);
    send_byte(8'h11); send_byte(8'h22);
    ByteValid = 1'b0; WordCount = 9'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("busy_start_err",  {31'd0, Error}, 32'd0);
    chk("busy_start_busy", {31'd0, Busy},  32'd1);
    send_byte(8'h33); send_byte(8'h44);
    send_word(32'h8877_6655);
    ByteValid = 1'b0;
    tick();
    chk("t4_done",   {31'd0, Done},  32'd1);
    chk("t4_nwrite", 32'(we_count),  32'd5);

    // Reset (with a simultaneous Start) after six bytes of a four-word load.
    sb.push_back('{addr: 32'h0, data: 32'h0403_0201});
    start_load(9'd4);
    send_word(32'h0403_0201);
    send_byte(8'h05); send_byte(8'h06);
    Reset = 1'b1; Start = 1'b1; WordCount = 9'd4;
    tick();
    Reset = 1'b0; Start = 1'b0;
    chk("abort_we",    {31'd0, MemWe},     32'd0);
    chk("abort_busy",  {31'd0, Busy},      32'd0);
    chk("abort_done",  {31'd0, Done},      32'd0);
    chk("abort_cpurn", {31'd0, CpuResetn}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_ready",  {31'd0, ByteReady}, 32'd0);
    chk("abort_nwrite", 32'(we_count),      32'd6);
    ByteValid = 1'b0;

    // Full-depth load.
    for (int k = 0; k < 256; k++) begin
      bt = 8'(k);
      sb.push_back('{addr: 32'(k) << 2, data: {8'(k >> 1) ^ 8'hC3, ~bt, bt ^ 8'h5A, bt}});
    end
    start_load(9'd256);
    for (int k = 0; k < 256; k++) begin
      bt = 8'(k);
      send_word({8'(k >> 1) ^ 8'hC3, ~bt, bt ^ 8'h5A, bt});
    end
    chk("full_last_addr", MemAddr, 32'h0000_03FC);
    ByteValid = 1'b0;
    tick();
    chk("full_done", {31'd0, Done}, 32'd1);
    ByteData = 8'h99; ByteValid = 1'b1;
    tick();
    chk("full_ready", {31'd0, ByteReady}, 32'd0);
    chk("full_done2", {31'd0, Done},      32'd1);
    ByteValid = 1'b0;
    wc = we_count;
    chk("full_nwrite", 32'(wc), 32'd262);
    chk("sb_empty",    32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
